fetch_pc: RTL and testbench

- Instruction-fetch and PC-sequencing stage for the 16-bit single-issue core.
- Holds the PC, requests instructions from instruction memory with a ready handshake, and presents each fetched instruction to decode/execute and to the flag/condition unit.
- Consumes the flag unit's branch-taken bit to select the next PC: sequential or PC-relative branch target. Stops on HALT.

---
 rtl/fetch_pc.sv | 125 ++++++++++++
 tb/tb_fetch_pc.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc.sv
`default_nettype none
//==============================================================================
// Module   : fetch_pc
// Purpose  : Instruction fetch and PC sequencing for the 16-bit single-issue
//            core. Requests one word, hands it downstream, then steps or
//            branches the PC. Optional macro FETCH_STALL_CNT_EN adds stall_cnt.
// Revision : 1.0 - initial release
//==============================================================================
module fetch_pc #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  B_OPCODE    = 4'hC,
    parameter logic [3:0]  HALT_OPCODE = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        ex_ready,
    input  logic        branch_taken,
    output logic [15:0] pc,
`ifdef FETCH_STALL_CNT_EN
    output logic [15:0] stall_cnt,
`endif
    output logic        halted
);

    localparam logic [1:0] c_ST_REQ   = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_HALT  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    // Holds off the first request for one cycle after reset deasserts.
    logic        r_armed;
    logic [15:0] r_pc;
    logic [15:0] r_instr;

    logic        w_fetch_done;
    logic        w_accept;
    logic        w_is_halt;
    logic        w_is_branch;
    logic [15:0] w_offset;
    logic [15:0] w_pc_seq;
    logic [15:0] w_pc_br;

    assign w_fetch_done = (r_state == c_ST_REQ) && r_armed && imem_rdy;
    assign w_accept     = (r_state == c_ST_ISSUE) && ex_ready;
    assign w_is_halt    = (r_instr[15:12] == HALT_OPCODE);
    assign w_is_branch  = (r_instr[15:12] == B_OPCODE);
    assign w_offset     = {{8{r_instr[7]}}, r_instr[7:0]};
    assign w_pc_seq     = r_pc + 16'd1;
    assign w_pc_br      = w_pc_seq + w_offset;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_REQ;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_armed <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_REQ: begin
                if (w_fetch_done)
                    w_next_state = c_ST_ISSUE;
            end
            c_ST_ISSUE: begin
                if (ex_ready)
                    w_next_state = w_is_halt ? c_ST_HALT : c_ST_REQ;
            end
            c_ST_HALT: w_next_state = c_ST_HALT;
            default:   w_next_state = c_ST_REQ;
        endcase
    end

    always_comb begin
        imem_req    = (r_state == c_ST_REQ) && r_armed;
        instr_valid = (r_state == c_ST_ISSUE);
        halted      = (r_state == c_ST_HALT);
    end

    // branch_taken only matters for an accepted B; HALT keeps its own address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_instr <= 16'h0000;
        end else begin
            if (w_fetch_done)
                r_instr <= imem_data;
            if (w_accept && !w_is_halt)
                r_pc <= (w_is_branch && branch_taken) ? w_pc_br : w_pc_seq;
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign instr     = r_instr;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = ((r_state == c_ST_REQ) && r_armed && !imem_rdy) ||
                     ((r_state == c_ST_ISSUE) && !ex_ready);

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= 16'h0000;
        else if (w_stall && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc.sv
`default_nettype none
//==============================================================================
// Module   : tb_fetch_pc
// Purpose  : Directed self-checking bench for fetch_pc (sequential fetch,
//            branches, stalls, wrap, HALT, reset mid-wait).
// Revision : 1.0 - initial release
//==============================================================================
module tb_fetch_pc;

    localparam logic [15:0] c_ADD = 16'h1234;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        ex_ready;
    logic        branch_taken;
    logic [15:0] pc;
    logic        halted;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    fetch_pc dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdy    (imem_rdy),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .ex_ready    (ex_ready),
        .branch_taken(branch_taken),
        .pc          (pc),
`ifdef FETCH_STALL_CNT_EN
        .stall_cnt   (stall_cnt),
`endif
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for a request, checks its address, returns data for one cycle.
    task automatic fetch(input logic [15:0] exp_addr, input logic [15:0] data);
        int n = 0;
        while (!imem_req && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", {31'd0, imem_req}, 32'd1);
        check("imem_addr", {16'd0, imem_addr}, {16'd0, exp_addr});
        check("pc", {16'd0, pc}, {16'd0, exp_addr});
        imem_rdy  = 1'b1;
        imem_data = data;
        @(negedge clk);
        imem_rdy  = 1'b0;
        check("instr", {16'd0, instr}, {16'd0, data});
        check("valid", {31'd0, instr_valid}, 32'd1);
        check("req_issue", {31'd0, imem_req}, 32'd0);
    endtask

    task automatic issue(input logic br);
        ex_ready     = 1'b1;
        branch_taken = br;
        @(negedge clk);
        ex_ready     = 1'b0;
        branch_taken = 1'b0;
        check("valid_drop", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; imem_rdy = 1'b0; imem_data = 16'h0000;
        ex_ready = 1'b0; branch_taken = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pc", {16'd0, pc}, 32'd0);
        check("rst_instr", {16'd0, instr}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        rst = 1'b0;
        check("req_after_rst", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        check("first_req", {31'd0, imem_req}, 32'd1);

        for (int i = 0; i < 5; i++) begin
            fetch(i[15:0], c_ADD);
            issue(1'b0);
        end

        // Memory stalls three cycles at 0005.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_req", {31'd0, imem_req}, 32'd1);
            check("stall_addr", {16'd0, imem_addr}, 32'h0005);
        end
        fetch(16'h0005, c_ADD);
`ifdef FETCH_STALL_CNT_EN
        check("stall_cnt_req", {16'd0, stall_cnt}, 32'd3);
`endif
        issue(1'b0);

        // Downstream stalls two cycles on a branch while branch_taken toggles.
        fetch(16'h0006, 16'hC009);
        branch_taken = 1'b1;
        @(negedge clk);
        check("hold_instr", {16'd0, instr}, 32'hC009);
        check("hold_pc", {16'd0, pc}, 32'h0006);
        check("hold_valid", {31'd0, instr_valid}, 32'd1);
        branch_taken = 1'b0;
        @(negedge clk);
        check("hold_instr2", {16'd0, instr}, 32'hC009);
        check("hold_pc2", {16'd0, pc}, 32'h0006);
`ifdef FETCH_STALL_CNT_EN
        check("stall_cnt_ex", {16'd0, stall_cnt}, 32'd5);
`endif
        issue(1'b1);

        fetch(16'h0010, 16'hC2FC); issue(1'b1);
        fetch(16'h000D, 16'h12FC); issue(1'b1);
        fetch(16'h000E, c_ADD);    issue(1'b0);
        fetch(16'h000F, c_ADD);    issue(1'b0);
        fetch(16'h0010, 16'hC2FC); issue(1'b0);
        fetch(16'h0011, 16'hC080); issue(1'b1);
        fetch(16'hFF92, 16'hC06C); issue(1'b1);
        fetch(16'hFFFF, c_ADD);    issue(1'b0);

        for (int i = 0; i < 7; i++) begin
            fetch(i[15:0], c_ADD);
            issue(1'b0);
        end
        fetch(16'h0007, 16'h0ABC);
        issue(1'b0);
        for (int i = 0; i < 4; i++) begin
            imem_rdy = i[0];
            @(negedge clk);
            check("halt_halted", {31'd0, halted}, 32'd1);
            check("halt_req", {31'd0, imem_req}, 32'd0);
            check("halt_pc", {16'd0, pc}, 32'h0007);
            check("halt_valid", {31'd0, instr_valid}, 32'd0);
        end
        imem_rdy = 1'b0;
`ifdef FETCH_STALL_CNT_EN
        check("stall_cnt_halt", {16'd0, stall_cnt}, 32'd5);
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst2_pc", {16'd0, pc}, 32'd0);
        check("rst2_halted", {31'd0, halted}, 32'd0);
        check("rst2_req", {31'd0, imem_req}, 32'd0);
        fetch(16'h0000, c_ADD);
        issue(1'b0);

        // Reset while waiting on memory at 0001; late imem_rdy must be ignored.
        @(negedge clk);
        rst       = 1'b1;
        imem_rdy  = 1'b1;
        imem_data = 16'hC0FF;
        @(negedge clk);
        rst = 1'b0;
        check("rstw_pc", {16'd0, pc}, 32'd0);
        check("rstw_req", {31'd0, imem_req}, 32'd0);
        check("rstw_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        check("late_valid", {31'd0, instr_valid}, 32'd0);
        check("late_instr", {16'd0, instr}, 32'd0);
        check("late_req", {31'd0, imem_req}, 32'd1);
        check("late_addr", {16'd0, imem_addr}, 32'd0);
`ifdef FETCH_STALL_CNT_EN
        check("stall_cnt_rst", {16'd0, stall_cnt}, 32'd0);
`endif
        imem_rdy = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
